// File: rtl/mem_port_arb.sv
// mem_port_arb: single-outstanding memory port arbiter between fetch and load/store requesters.
// Define MEM_PORT_ARB_FAIR_EN for alternating grants on contention; default is fixed ls-over-if priority.
module mem_port_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] LS_BUSY = 2'd2;
  logic [1:0] state;
  logic       idle;
  logic       ls_win;
  assign idle = (state == IDLE) && !rst;
`ifdef MEM_PORT_ARB_FAIR_EN
  logic last_if;
  always_ff @(posedge clk) begin
    if (rst) last_if <= 1'b1;
    else if (if_gnt || ls_gnt) last_if <= if_gnt;
  end
  // On contention, whoever was not granted last wins
  assign ls_win = ls_req && (!if_req || last_if);
`else
  assign ls_win = ls_req;
`endif
  assign ls_gnt  = idle && ls_win;
  assign if_gnt  = idle && if_req && !ls_win;
  assign mem_req = (state != IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rdata     <= '0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (if_gnt) begin
        state     <= IF_BUSY;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end else if (ls_gnt) begin
        state     <= LS_BUSY;
        mem_we    <= ls_we;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
        mem_be    <= ls_be;
      end else if (state != IDLE && mem_ready) begin
        state     <= IDLE;
        if_rvalid <= (state == IF_BUSY);
        ls_rvalid <= (state == LS_BUSY);
        rdata     <= mem_we ? rdata : mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arb;
`ifdef MEM_PORT_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic        clk = 0, rst = 1;
  logic        if_req = 0, ls_req = 0, ls_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, mem_rdata = 0;
  logic [3:0]  ls_be = 0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int checks = 0, errors = 0;

  mem_port_arb dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; if_req = 1; ls_req = 1;
    adv; adv; #1;
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got %b exp 0", if_gnt); end
    checks++; if (ls_gnt !== 1'b0) begin errors++; $display("FAIL rst_ls_gnt got %b exp 0", ls_gnt); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {if_rvalid, ls_rvalid}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin errors++; $display("FAIL rst_mem_fields got %h exp 0", {mem_addr, mem_wdata, mem_be}); end
    rst = 0; if_req = 0; ls_req = 0;
    adv;
  endtask

  task automatic test_fetch;
    if_req = 1; if_addr = 32'h100; #1;
    checks++; if ({if_gnt, ls_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt got %b exp 10", {if_gnt, ls_gnt}); end
    adv;
    if_req = 0; if_addr = 32'hFFFF; mem_ready = 1; mem_rdata = 32'hA5A51234; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_mem got req %b addr %h exp 1 100", mem_req, mem_addr); end
    checks++; if (mem_we !== 1'b0 || mem_be !== 4'hF) begin errors++; $display("FAIL fetch_we_be got %b %h exp 0 f", mem_we, mem_be); end
    adv;
    mem_ready = 0; #1;
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b10) begin errors++; $display("FAIL fetch_rvalid got %b exp 10", {if_rvalid, ls_rvalid}); end
    checks++; if (rdata !== 32'hA5A51234) begin errors++; $display("FAIL fetch_rdata got %h exp a5a51234", rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_mem_drop got %b exp 0", mem_req); end
    adv; #1;
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %b exp 0", if_rvalid); end
  endtask

  task automatic test_store;
    int pulses = 0;
    ls_req = 1; ls_we = 1; ls_addr = 32'h2004; ls_wdata = 32'hDEADBEEF; ls_be = 4'b0011; #1;
    checks++; if ({if_gnt, ls_gnt} !== 2'b01) begin errors++; $display("FAIL store_gnt got %b exp 01", {if_gnt, ls_gnt}); end
    adv;
    ls_req = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0; ls_we = 0;
    for (int i = 1; i <= 4; i++) begin
      mem_ready = (i == 4); mem_rdata = 32'h5555AAAA; #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2004 || mem_wdata !== 32'hDEADBEEF || mem_be !== 4'b0011) begin
        errors++; $display("FAIL store_stable cyc %0d got %b %b %h %h %b", i, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
      end
      if (ls_rvalid) pulses++;
      adv;
    end
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ls_rvalid) pulses++;
      if (i == 0) begin
        checks++; if (ls_rvalid !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL store_ack got rvalid %b req %b exp 1 0", ls_rvalid, mem_req); end
      end
      adv;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL store_pulses got %0d exp 1", pulses); end
    checks++; if (rdata !== 32'hA5A51234) begin errors++; $display("FAIL store_rdata got %h exp a5a51234", rdata); end
  endtask

  task automatic test_arb;
    bit got[4];
    int n = 0;
    rst = 1; adv; rst = 0;
    if_req = 1; ls_req = 1; ls_we = 0; mem_ready = 1; if_addr = 32'h10; ls_addr = 32'h20;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      checks++; if (if_gnt && ls_gnt) begin errors++; $display("FAIL arb_both got 11 exp one-hot"); end
      if (if_gnt || ls_gnt) begin got[n] = ls_gnt; n++; end
      adv;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL arb_count got %0d exp 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== (FAIR ? (i % 2 == 0) : 1'b1)) begin
        errors++; $display("FAIL arb_order idx %0d got ls=%b exp ls=%b", i, got[i], FAIR ? (i % 2 == 0) : 1'b1);
      end
    end
    if_req = 0; ls_req = 0;
    adv; adv;
    mem_ready = 0;
    adv;
  endtask

  task automatic test_reset_abort;
    ls_req = 1; ls_we = 0; ls_addr = 32'h3000; #1;
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL abort_gnt got %b exp 1", ls_gnt); end
    adv;
    ls_req = 0; mem_ready = 0; #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_busy got %b exp 1", mem_req); end
    adv;
    rst = 1; if_req = 1; #1;
    checks++; if ({if_gnt, ls_gnt} !== 2'b00) begin errors++; $display("FAIL abort_rst_gnt got %b exp 00", {if_gnt, ls_gnt}); end
    adv;
    rst = 0; if_req = 0; mem_ready = 1; mem_rdata = 32'h11111111; #1;
    checks++; if (mem_req !== 1'b0 || ls_rvalid !== 1'b0) begin errors++; $display("FAIL abort_next got req %b rvalid %b exp 0 0", mem_req, ls_rvalid); end
    adv;
    mem_ready = 0; #1;
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL abort_late_ready got %b exp 00", {if_rvalid, ls_rvalid}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata got %h exp 0", rdata); end
    if_req = 1; if_addr = 32'h44; #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL abort_idle_gnt got %b exp 1", if_gnt); end
    adv;
    if_req = 0; mem_ready = 1; mem_rdata = 32'h0BADF00D;
    adv;
    mem_ready = 0; #1;
    checks++; if (if_rvalid !== 1'b1 || rdata !== 32'h0BADF00D) begin errors++; $display("FAIL abort_recover got %b %h exp 1 0badf00d", if_rvalid, rdata); end
    adv;
  endtask

  task automatic test_idle_ready;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1; mem_rdata = $urandom; #1;
      checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL idle_rvalid got %b exp 00", {if_rvalid, ls_rvalid}); end
      checks++; if (rdata !== 32'h0BADF00D) begin errors++; $display("FAIL idle_rdata got %h exp 0badf00d", rdata); end
      adv;
    end
    mem_ready = 0;
    adv;
  endtask

  task automatic test_back_to_back;
    ls_req = 1; ls_we = 0; ls_addr = 32'h40; #1;
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL b2b_ls_gnt got %b exp 1", ls_gnt); end
    adv;
    ls_req = 0; if_req = 1; if_addr = 32'h80; #1;
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL b2b_busy1 got %b exp 0", if_gnt); end
    adv;
    mem_ready = 1; mem_rdata = 32'hCAFE0001; #1;
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL b2b_busy2 got %b exp 0", if_gnt); end
    adv;
    mem_ready = 0; #1;
    checks++; if (ls_rvalid !== 1'b1 || rdata !== 32'hCAFE0001) begin errors++; $display("FAIL b2b_ls_done got %b %h exp 1 cafe0001", ls_rvalid, rdata); end
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL b2b_if_gnt got %b exp 1", if_gnt); end
    adv;
    if_req = 0; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL b2b_if_mem got %b %h exp 1 80", mem_req, mem_addr); end
    mem_ready = 1;
    adv;
    mem_ready = 0;
    adv;
  endtask

  task automatic test_random;
    bit busy = 0, c_ls = 0, c_we = 0, e_ifv = 0, e_lsv = 0, last_if = 1, pick_if, pick_ls;
    logic [31:0] c_addr = 0, c_wdata = 0, e_rdata = 0;
    logic [3:0]  c_be = 0;
    rst = 1; if_req = 0; ls_req = 0; adv; rst = 0;
    for (int i = 0; i < 500; i++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
      if (!ls_req && $urandom_range(0, 2) == 0) begin
        ls_req = 1; ls_we = 1'($urandom_range(0, 1)); ls_addr = $urandom; ls_wdata = $urandom; ls_be = 4'($urandom);
      end
      mem_ready = ($urandom_range(0, 2) == 0); mem_rdata = $urandom;
      #1;
      pick_ls = !busy && ls_req && (!FAIR || !if_req || last_if);
      pick_if = !busy && if_req && !pick_ls;
      checks++; if ({if_gnt, ls_gnt} !== {pick_if, pick_ls}) begin errors++; $display("FAIL rnd_gnt cyc %0d got %b exp %b", i, {if_gnt, ls_gnt}, {pick_if, pick_ls}); end
      checks++; if (mem_req !== busy) begin errors++; $display("FAIL rnd_mem_req cyc %0d got %b exp %b", i, mem_req, busy); end
      checks++; if ({if_rvalid, ls_rvalid} !== {e_ifv, e_lsv}) begin errors++; $display("FAIL rnd_rvalid cyc %0d got %b exp %b", i, {if_rvalid, ls_rvalid}, {e_ifv, e_lsv}); end
      checks++; if (rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", i, rdata, e_rdata); end
      if (busy) begin
        checks++;
        if (mem_addr !== c_addr || mem_we !== c_we || mem_be !== c_be || (c_ls && mem_wdata !== c_wdata)) begin
          errors++; $display("FAIL rnd_mem cyc %0d got %h %b %h %h exp %h %b %h %h", i, mem_addr, mem_we, mem_be, mem_wdata, c_addr, c_we, c_be, c_wdata);
        end
      end
      e_ifv = 0; e_lsv = 0;
      if (busy && mem_ready) begin
        busy = 0; e_ifv = !c_ls; e_lsv = c_ls;
        if (!c_we) e_rdata = mem_rdata;
      end else if (pick_ls) begin
        busy = 1; c_ls = 1; c_we = ls_we; c_addr = ls_addr; c_wdata = ls_wdata; c_be = ls_be; last_if = 0;
      end else if (pick_if) begin
        busy = 1; c_ls = 0; c_we = 0; c_addr = if_addr; c_be = 4'hF; last_if = 1;
      end
      adv;
      if (pick_if) if_req = 0;
      if (pick_ls) ls_req = 0;
    end
    if_req = 0; ls_req = 0; mem_ready = 0;
  endtask

  initial begin
    #1;
    test_reset;
    test_fetch;
    test_store;
    test_arb;
    test_reset_abort;
    test_idle_ready;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
